// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic phase controller.
// Phase encodings, lamp codes and default timing used by controller and bench.
package traffic_pkg;

   typedef enum logic [2:0] {
      R2G   = 3'd0,
      R2Y   = 3'd1,
      AR_A  = 3'd2,
      R1G   = 3'd3,
      R1Y   = 3'd4,
      AR_B  = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   localparam int T_PED = 3;
   localparam int T_RST = 18;

   // Successor in the normal cycle; FLASH always exits through AR_A.
   function automatic state_t next_phase(state_t s);
      state_t n;
      unique case (s)
         R2G:     n = R2Y;
         R2Y:     n = AR_A;
         AR_A:    n = R1G;
         R1G:     n = R1Y;
         R1Y:     n = AR_B;
         AR_B:    n = R2G;
         default: n = AR_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl.sv
// Two-road signal phase sequencer with pedestrian truncation and night flash.
// All state advances only on the 1 Hz tick enable.
module traffic_phase_ctrl #(
   parameter int T_PED = traffic_pkg::T_PED,
   parameter int T_RST = traffic_pkg::T_RST
) (
   input  logic       clk100M,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [4:0] cfg_green1,
   input  logic [4:0] cfg_green2,
   input  logic [2:0] cfg_yellow,
   input  logic       ped_req1,
   input  logic       ped_req2,
   input  logic       night_mode,
   output logic [2:0] led1,
   output logic [2:0] led2,
   output logic       walk1,
   output logic       walk2,
   output logic [4:0] time_left,
   output logic [2:0] phase
);
   import traffic_pkg::*;

   localparam logic [4:0] PED_TL = 5'(T_PED);
   localparam logic [4:0] RST_TL = 5'(T_RST);

   state_t     state, state_n, adv;
   logic [4:0] tl_q, tl_n, load_v;
   logic       pend1, pend1_n;
   logic       pend2, pend2_n;
   logic       walk1_n, walk2_n;
   logic       flash_q, flash_n;
   logic       trunc;

   always_ff @(posedge clk100M or negedge rst_n) begin
      if (!rst_n) begin
         state   <= R2G;
         tl_q    <= RST_TL;
         pend1   <= 1'b0;
         pend2   <= 1'b0;
         walk1   <= 1'b0;
         walk2   <= 1'b0;
         flash_q <= 1'b0;
      end else begin
         state   <= state_n;
         tl_q    <= tl_n;
         pend1   <= pend1_n;
         pend2   <= pend2_n;
         walk1   <= walk1_n;
         walk2   <= walk2_n;
         flash_q <= flash_n;
      end
   end

   assign adv = next_phase(state);

   always_comb begin
      unique case (adv)
         R2G:      load_v = cfg_green2;
         R1G:      load_v = cfg_green1;
         R2Y, R1Y: load_v = {2'b00, cfg_yellow};
         default:  load_v = '0;
      endcase
   end

   // A pending crossing of the road now green cuts its remaining green short.
   assign trunc = ((state == R1G) && pend1) || ((state == R2G) && pend2);

   always_comb begin
      state_n = state;
      tl_n    = tl_q;
      flash_n = flash_q;
      walk1_n = walk1;
      walk2_n = walk2;
      pend1_n = pend1 | ped_req1;
      pend2_n = pend2 | ped_req2;
      if (state == FLASH) begin
         pend1_n = 1'b0;
         pend2_n = 1'b0;
         walk1_n = 1'b0;
         walk2_n = 1'b0;
      end
      if (tick) begin
         if (state == FLASH) begin
            if (night_mode) begin
               flash_n = ~flash_q;
            end else begin
               state_n = AR_A;
               tl_n    = '0;
            end
         end else if (tl_q == '0) begin
            walk1_n = 1'b0;
            walk2_n = 1'b0;
            if ((state == AR_A || state == AR_B) && night_mode) begin
               state_n = FLASH;
               flash_n = 1'b0;
            end else begin
               state_n = adv;
               tl_n    = load_v;
               if (adv == R2G) begin
                  walk1_n = pend1 | ped_req1;
                  pend1_n = 1'b0;
               end
               if (adv == R1G) begin
                  walk2_n = pend2 | ped_req2;
                  pend2_n = 1'b0;
               end
            end
         end else if (trunc && (tl_q > PED_TL)) begin
            tl_n = PED_TL;
         end else begin
            tl_n = tl_q - 5'd1;
         end
      end
   end

   always_comb begin
      led1 = RED;
      led2 = RED;
      unique case (1'b1)
         state == R2G: led2 = GRN;
         state == R2Y: led2 = YEL;
         state == R1G: led1 = GRN;
         state == R1Y: led1 = YEL;
         state == FLASH: begin
            led1 = flash_q ? OFF : YEL;
            led2 = flash_q ? OFF : YEL;
         end
         default: ;
      endcase
   end

   assign time_left = tl_q;
   assign phase     = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus a random run
// checked against a phase-table reference model.
module tb_traffic_phase_ctrl;
   import traffic_pkg::*;

   localparam int TPED = 3;
   localparam int TRST = 18;

   logic       clk100M = 1'b0;
   logic       rst_n, tick, ped_req1, ped_req2, night_mode;
   logic [4:0] cfg_green1, cfg_green2;
   logic [2:0] cfg_yellow;
   logic [2:0] led1, led2, phase;
   logic       walk1, walk2;
   logic [4:0] time_left;

   int errs = 0;
   int checks = 0;

   // model: index into cycle R2G,R2Y,AR_A,R1G,R1Y,AR_B (0..5), FLASH = 6
   int m_st, m_tl;
   bit m_p1, m_p2, m_w1, m_w2, m_fl;

   traffic_phase_ctrl dut (
      .clk100M(clk100M), .rst_n(rst_n), .tick(tick),
      .cfg_green1(cfg_green1), .cfg_green2(cfg_green2),
      .cfg_yellow(cfg_yellow), .ped_req1(ped_req1),
      .ped_req2(ped_req2), .night_mode(night_mode),
      .led1(led1), .led2(led2), .walk1(walk1), .walk2(walk2),
      .time_left(time_left), .phase(phase)
   );

   always #5 clk100M = ~clk100M;

   function automatic logic [2:0] enc(int s);
      case (s)
         0: return 3'd0;
         1: return 3'd1;
         2: return 3'd2;
         3: return 3'd3;
         4: return 3'd4;
         5: return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   function automatic int dur(int s);
      case (s)
         0: return int'(cfg_green2);
         3: return int'(cfg_green1);
         1, 4: return int'(cfg_yellow);
         default: return 0;
      endcase
   endfunction

   function automatic logic [15:0] m_vec();
      logic [5:0] l;
      case (m_st)
         0: l = {3'b100, 3'b001};
         1: l = {3'b100, 3'b010};
         3: l = {3'b001, 3'b100};
         4: l = {3'b010, 3'b100};
         6: l = m_fl ? 6'b000_000 : 6'b010_010;
         default: l = {3'b100, 3'b100};
      endcase
      return {l, m_w1, m_w2, 5'(m_tl), enc(m_st)};
   endfunction

   function automatic void model_reset();
      m_st = 0; m_tl = TRST;
      m_p1 = 0; m_p2 = 0; m_w1 = 0; m_w2 = 0; m_fl = 0;
   endfunction

   function automatic void model_step(bit t, bit q1, bit q2, bit nm);
      bit np1, np2;
      np1 = m_p1 | q1;
      np2 = m_p2 | q2;
      if (m_st == 6) begin
         np1 = 0; np2 = 0;
      end
      if (t) begin
         if (m_st == 6) begin
            if (nm) m_fl = !m_fl;
            else begin m_st = 2; m_tl = 0; end
         end else if (m_tl == 0) begin
            m_w1 = 0; m_w2 = 0;
            if ((m_st == 2 || m_st == 5) && nm) begin
               m_st = 6; m_fl = 0;
            end else begin
               m_st = (m_st + 1) % 6;
               m_tl = dur(m_st);
               if (m_st == 0) begin m_w1 = m_p1 | q1; np1 = 0; end
               if (m_st == 3) begin m_w2 = m_p2 | q2; np2 = 0; end
            end
         end else if (((m_st == 3 && m_p1) || (m_st == 0 && m_p2))
                      && m_tl > TPED) begin
            m_tl = TPED;
         end else begin
            m_tl = m_tl - 1;
         end
      end
      m_p1 = np1;
      m_p2 = np2;
   endfunction

   task automatic cyc(input bit t, input bit q1 = 1'b0, input bit q2 = 1'b0);
      tick = t; ped_req1 = q1; ped_req2 = q2;
      model_step(t, q1, q2, night_mode);
      @(posedge clk100M);
      #1;
      tick = 0; ped_req1 = 0; ped_req2 = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk100M);
      #1;
      rst_n = 1;
   endtask

   task automatic tick_until(input logic [2:0] st, input int tl);
      int n = 0;
      while (!(phase === st && time_left === 5'(tl)) && n < 300) begin
         cyc(1);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errs++;
         $display("FAIL wait_phase: got phase %0d tl %0d, want phase %0d tl %0d",
                  phase, time_left, st, tl);
      end
   endtask

   task automatic test_reset();
      cfg_green1 = 5; cfg_green2 = 18; cfg_yellow = 2;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk100M);
      #1;
      checks++;
      if ({led1, led2} !== 6'b100_001) begin
         errs++; $display("FAIL reset_leds: got %b want 100001", {led1, led2});
      end
      checks++;
      if ({walk1, walk2} !== 2'b00) begin
         errs++; $display("FAIL reset_walk: got %b want 00", {walk1, walk2});
      end
      checks++;
      if (time_left !== 5'd18 || phase !== 3'd0) begin
         errs++;
         $display("FAIL reset_tl_phase: got %0d/%0d want 18/0", time_left, phase);
      end
      rst_n = 1;
      cyc(0); cyc(0);
      checks++;
      if (time_left !== 5'd18 || phase !== 3'd0) begin
         errs++;
         $display("FAIL hold_no_tick: got %0d/%0d want 18/0", time_left, phase);
      end
   endtask

   task automatic test_basic_cycle();
      int         durs[$];
      logic [2:0] seq[$];
      logic [2:0] cur;
      int         cnt;
      int         exp_d[6] = '{19, 3, 1, 6, 3, 1};
      logic [2:0] exp_s[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      do_reset();
      cur = phase;
      cnt = 0;
      for (int i = 0; i < 60 && durs.size() < 6; i++) begin
         cyc(1);
         cnt++;
         checks++;
         if ({led1, led2, walk1, walk2, time_left, phase} !== m_vec()) begin
            errs++;
            $display("FAIL basic_model: got %h want %h",
                     {led1, led2, walk1, walk2, time_left, phase}, m_vec());
         end
         if (phase !== cur) begin
            durs.push_back(cnt);
            seq.push_back(phase);
            cur = phase;
            cnt = 0;
         end
      end
      checks++;
      if (durs.size() != 6) begin
         errs++;
         $display("FAIL basic_phases: got %0d phase changes want 6", durs.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (durs[i] != exp_d[i] || seq[i] !== exp_s[i]) begin
               errs++;
               $display("FAIL basic_dur%0d: got %0d ticks to %0d want %0d to %0d",
                        i, durs[i], seq[i], exp_d[i], exp_s[i]);
            end
         end
      end
   endtask

   task automatic test_ped_trunc();
      int n = 0;
      do_reset();
      tick_until(3'd0, 12);
      cyc(0, 0, 1);
      cyc(1);
      checks++;
      if (time_left !== 5'd3 || phase !== 3'd0) begin
         errs++;
         $display("FAIL trunc2: got tl %0d ph %0d want 3 0", time_left, phase);
      end
      repeat (3) cyc(1);
      checks++;
      if (phase !== 3'd0 || time_left !== 5'd0) begin
         errs++;
         $display("FAIL trunc2_end: got tl %0d ph %0d want 0 0", time_left, phase);
      end
      cyc(1);
      checks++;
      if (phase !== 3'd1) begin
         errs++; $display("FAIL trunc2_r2y: got ph %0d want 1", phase);
      end
      tick_until(3'd3, 5);
      while (phase === 3'd3 && n < 40) begin
         checks++;
         if (walk2 !== 1'b1) begin
            errs++; $display("FAIL walk2_r1g: got %b want 1", walk2);
         end
         cyc(1);
         n++;
      end
      checks++;
      if (phase !== 3'd4 || walk2 !== 1'b0) begin
         errs++;
         $display("FAIL walk2_off: got ph %0d walk2 %b want 4 0", phase, walk2);
      end
   endtask

   task automatic test_entry_req();
      int n = 0;
      cfg_green1 = 10;
      tick_until(3'd5, 0);
      cyc(1, 1, 0);
      checks++;
      if (phase !== 3'd0 || walk1 !== 1'b1 || time_left !== 5'd18) begin
         errs++;
         $display("FAIL entry_walk1: got ph %0d w %b tl %0d want 0 1 18",
                  phase, walk1, time_left);
      end
      while (phase === 3'd0 && n < 40) begin
         checks++;
         if (walk1 !== 1'b1) begin
            errs++; $display("FAIL walk1_hold: got %b want 1", walk1);
         end
         cyc(1);
         n++;
      end
      checks++;
      if (phase !== 3'd1 || walk1 !== 1'b0) begin
         errs++;
         $display("FAIL walk1_off: got ph %0d w %b want 1 0", phase, walk1);
      end
      tick_until(3'd3, 10);
      cyc(1);
      checks++;
      if (time_left !== 5'd9) begin
         errs++; $display("FAIL pend1_cleared: got tl %0d want 9", time_left);
      end
   endtask

   task automatic test_night();
      night_mode = 1;
      tick_until(3'd5, 0);
      cyc(1);
      checks++;
      if (phase !== 3'd6 || {led1, led2} !== 6'b010_010 || time_left !== 5'd0
          || {walk1, walk2} !== 2'b00) begin
         errs++;
         $display("FAIL flash_enter: got ph %0d leds %b tl %0d want 6 010010 0",
                  phase, {led1, led2}, time_left);
      end
      cyc(0, 0, 1);
      checks++;
      if ({led1, led2} !== 6'b010_010) begin
         errs++; $display("FAIL flash_hold: got %b want 010010", {led1, led2});
      end
      cyc(1);
      checks++;
      if ({led1, led2} !== 6'b000_000 || time_left !== 5'd0) begin
         errs++;
         $display("FAIL flash_off: got %b tl %0d want 000000 0", {led1, led2}, time_left);
      end
      cyc(1);
      checks++;
      if ({led1, led2} !== 6'b010_010) begin
         errs++; $display("FAIL flash_on: got %b want 010010", {led1, led2});
      end
      night_mode = 0;
      cyc(1);
      checks++;
      if (phase !== 3'd2 || time_left !== 5'd0 || {led1, led2} !== 6'b100_100) begin
         errs++;
         $display("FAIL flash_exit: got ph %0d tl %0d leds %b want 2 0 100100",
                  phase, time_left, {led1, led2});
      end
      cyc(1);
      checks++;
      if (phase !== 3'd3 || time_left !== 5'd10 || walk2 !== 1'b0) begin
         errs++;
         $display("FAIL flash_to_r1g: got ph %0d tl %0d w2 %b want 3 10 0",
                  phase, time_left, walk2);
      end
   endtask

   task automatic test_async_reset();
      tick_until(3'd4, 1);
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({led1, led2, walk1, walk2, time_left, phase} !==
          {6'b100_001, 2'b00, 5'd18, 3'd0}) begin
         errs++;
         $display("FAIL async_reset: got %h want %h",
                  {led1, led2, walk1, walk2, time_left, phase},
                  {6'b100_001, 2'b00, 5'd18, 3'd0});
      end
      #1;
      rst_n = 1;
      model_reset();
      cyc(0);
      cyc(1);
      checks++;
      if (time_left !== 5'd17 || phase !== 3'd0) begin
         errs++;
         $display("FAIL first_tick: got tl %0d ph %0d want 17 0", time_left, phase);
      end
   endtask

   task automatic test_both();
      cfg_green1 = 15;
      tick_until(3'd3, 10);
      cyc(0, 1, 1);
      cyc(1);
      checks++;
      if (time_left !== 5'd3 || phase !== 3'd3) begin
         errs++;
         $display("FAIL both_trunc1: got tl %0d ph %0d want 3 3", time_left, phase);
      end
      tick_until(3'd5, 0);
      cyc(1);
      checks++;
      if (phase !== 3'd0 || time_left !== 5'd18 || walk1 !== 1'b1) begin
         errs++;
         $display("FAIL both_r2g: got ph %0d tl %0d w1 %b want 0 18 1",
                  phase, time_left, walk1);
      end
      cyc(1);
      checks++;
      if (time_left !== 5'd3 || walk1 !== 1'b1) begin
         errs++;
         $display("FAIL both_trunc2: got tl %0d w1 %b want 3 1", time_left, walk1);
      end
   endtask

   task automatic test_random();
      logic [15:0] got;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            cfg_green1 = 5'($urandom_range(0, 12));
            cfg_green2 = 5'($urandom_range(0, 12));
            cfg_yellow = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 149) == 0) night_mode = ~night_mode;
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 0;
            model_reset();
            #1;
            rst_n = 1;
         end
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0);
         got = {led1, led2, walk1, walk2, time_left, phase};
         checks++;
         if (got !== m_vec()) begin
            errs++;
            $display("FAIL random_%0d: got %h want %h", i, got, m_vec());
         end
      end
      night_mode = 0;
   endtask

   initial begin
      rst_n = 0; tick = 0; ped_req1 = 0; ped_req2 = 0; night_mode = 0;
      cfg_green1 = 5; cfg_green2 = 18; cfg_yellow = 2;
      model_reset();
      test_reset();
      test_basic_cycle();
      test_ped_trunc();
      test_entry_req();
      test_night();
      test_async_reset();
      test_both();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter T_PED, default 3: pedestrian-truncated green remainder, in ticks.
REQ-002 SHALL have parameter T_RST, default 18: time_left value at reset.
REQ-003 SHALL have port clk100M, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tick, input, 1 bit: one-cycle 1 Hz enable from the parent's freqdiv instance.
REQ-006 SHALL have port cfg_green1, input, 5 bits: road-1 green length minus 1, in ticks.
REQ-007 SHALL have port cfg_green2, input, 5 bits: road-2 green length minus 1, in ticks.
REQ-008 SHALL have port cfg_yellow, input, 3 bits: yellow length minus 1, in ticks.
REQ-009 SHALL have port ped_req1, input, 1 bit: pedestrian request to cross road 1; level input, already synchronised.
REQ-010 SHALL have port ped_req2, input, 1 bit: pedestrian request to cross road 2; level input, already synchronised.
REQ-011 SHALL have port night_mode, input, 1 bit: requests flashing-yellow operation.
REQ-012 SHALL have port led1, output, 3 bits: road-1 lamps; 100 red, 010 yellow, 001 green, 000 dark.
REQ-013 SHALL have port led2, output, 3 bits: road-2 lamps; same encoding as led1.
REQ-014 SHALL have port walk1, output, 1 bit: road-1 crossing permitted.
REQ-015 SHALL have port walk2, output, 1 bit: road-2 crossing permitted.
REQ-016 SHALL have port time_left, output, 5 bits: ticks remaining in the current phase.
REQ-017 SHALL have port phase, output, 3 bits: current state encoding.

Function
REQ-018 SHALL implement the states R2G, R2Y, AR_A, R1G, R1Y, AR_B and FLASH; cyclic order is R2G, R2Y, AR_A, R1G, R1Y, AR_B, then R2G.
REQ-019 SHALL drive lamps per state as led1/led2: R2G 100/001; R2Y 100/010; AR_A and AR_B 100/100; R1G 001/100; R1Y 010/100.
REQ-020 SHALL update time_left and state only in cycles with tick=1; when tick=0, all state holds.
REQ-021 SHALL decrement time_left on a tick when it is nonzero; on a tick when it is 0, SHALL advance state and load the new duration.
REQ-022 SHALL load durations on entry as follows: green = cfg_green1 or cfg_green2 sampled that cycle; yellow = cfg_yellow zero-extended; all-red = 0. A phase therefore lasts (load+1) ticks.
REQ-023 SHALL set pending flag pendN on any cycle with ped_reqN=1, and hold it until it is served.
REQ-024 SHALL load time_left with T_PED on a tick in R1G with pend1=1 and time_left>T_PED, instead of decrementing; the same rule SHALL apply to R2G with pend2. With time_left<=T_PED there SHALL be no change to normal counting.
REQ-025 SHALL, on entry to R2G, set walk1=pend1 (including a ped_req1 present in the entry cycle) and clear pend1; walk1 SHALL deassert on leaving R2G. Symmetrically, entry to R1G SHALL serve walk2 and pend2.
REQ-026 SHALL serve a request raised while that road is already red at the next entry to the opposite green, never mid-phase.
REQ-027 SHALL allow both requests pending at once; only the road currently green is truncated.
REQ-028 SHALL enter FLASH instead of the next green when night_mode=1 at the terminal tick (time_left=0) of AR_A or AR_B; night_mode SHALL be ignored in other states.
REQ-029 SHALL, in FLASH: hold time_left at 0, force walk1/walk2 to 0, clear pend1/pend2, and set led1=led2 alternating 010 and 000 on each tick, starting at 010.
REQ-030 SHALL leave FLASH on a tick with night_mode=0, going to AR_A (time_left 0) and then R1G.
REQ-031 SHALL keep time_left at 5 bits with no wrap below 0.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously set: state R2G, time_left=T_RST, led1=100, led2=001, walk1=walk2=0, pend1=pend2=0, flash phase=0.
REQ-033 SHALL resume at R2G from a reset asserted mid-phase (including FLASH), with the first decrement on the first tick after release.

Structure
REQ-034 SHALL take from shared package traffic_pkg the state encodings, the lamp codes (RED, YEL, GRN, OFF), T_PED and T_RST.
REQ-035 SHALL have no sub-module; tick generation stays in the parent's freqdiv.

Verification
REQ-036 SHALL cover this case: reset with cfg_green1=5, cfg_green2=18, cfg_yellow=2, no requests -> R2G 19 ticks, R2Y 3, AR_A 1, R1G 6, R1Y 3, AR_B 1.
REQ-037 SHALL cover this case: ped_req2 pulsed in R2G with time_left=12 -> next tick time_left=3, R2Y after 4 more ticks, walk2=1 throughout following R1G.
REQ-038 SHALL cover this case: ped_req1 pulsed in the same cycle as entry to R2G -> walk1=1 that R2G, pend1=0 afterwards.
REQ-039 SHALL cover this case: night_mode=1 during R1G -> FLASH entered after AR_B; led1=led2 toggling 010/000 per tick; night_mode=0 -> AR_A then R1G.
REQ-040 SHALL cover this case: rst_n low mid-R1Y and between ticks -> outputs at reset values immediately, without waiting for a clock edge.
REQ-041 SHALL cover this case: both requests set in R1G with time_left=10 -> road 1 truncated to 3; road 2 unaffected until R2G entry.
